// File: rtl/serial_compare_ctrl.sv
// Serial magnitude comparator: walks one 2-bit digit per cycle, MSB first,
// reusing a single digit slice for operands of width 2N.
module serial_compare_ctrl #(
  parameter int N          = 4,
  parameter bit EARLY_EXIT = 1'b1,
  parameter int SW         = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2*N-1:0] X,
  input  logic [2*N-1:0] Y,
  input  logic          negselect,
  output logic          busy,
  output logic          done,
  output logic          lout,
  output logic          gout,
  output logic          eout,
  output logic [SW-1:0] steps
);

  localparam int W  = 2 * N;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    x_reg, x_next;
  logic [W-1:0]    y_reg, y_next;
  logic            neg_reg, neg_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic            lout_reg, lout_next;
  logic            gout_reg, gout_next;
  logic            eout_reg, eout_next;
  logic [SW-1:0]   steps_reg, steps_next;
  logic            done_reg, done_next;

  logic [1:0]      xdig [N];
  logic [1:0]      ydig [N];
  logic [1:0]      xd, yd;
  logic            sign_split;
  logic            dec_lt, dec_gt;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_digit
      assign xdig[gi] = x_reg[2*gi+1:2*gi];
      assign ydig[gi] = y_reg[2*gi+1:2*gi];
    end
  endgenerate

  assign xd = xdig[idx_reg];
  assign yd = ydig[idx_reg];

  // On the top digit of a signed compare, differing signs settle it outright.
  assign sign_split = neg_reg && (idx_reg == IW'(N - 1)) && (x_reg[W-1] != y_reg[W-1]);

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    neg_next   = neg_reg;
    idx_next   = idx_reg;
    lout_next  = lout_reg;
    gout_next  = gout_reg;
    eout_next  = eout_reg;
    steps_next = steps_reg;
    done_next  = 1'b0;
    dec_lt     = 1'b0;
    dec_gt     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          x_next     = X;
          y_next     = Y;
          neg_next   = negselect;
          idx_next   = IW'(N - 1);
          lout_next  = 1'b0;
          gout_next  = 1'b0;
          eout_next  = 1'b0;
          steps_next = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        steps_next = steps_reg + SW'(1);
        // A decided result is frozen; later digits only consume cycles.
        if (!(lout_reg || gout_reg)) begin
          if (sign_split) begin
            dec_lt = x_reg[W-1];
            dec_gt = y_reg[W-1];
          end else begin
            dec_lt = (xd < yd);
            dec_gt = (xd > yd);
          end
        end
        lout_next = lout_reg | dec_lt;
        gout_next = gout_reg | dec_gt;
        if ((EARLY_EXIT && (dec_lt || dec_gt)) || (idx_reg == '0)) begin
          eout_next  = !(lout_next || gout_next);
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          idx_next = idx_reg - IW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      neg_reg   <= 1'b0;
      idx_reg   <= '0;
      lout_reg  <= 1'b0;
      gout_reg  <= 1'b0;
      eout_reg  <= 1'b0;
      steps_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      neg_reg   <= neg_next;
      idx_reg   <= idx_next;
      lout_reg  <= lout_next;
      gout_reg  <= gout_next;
      eout_reg  <= eout_next;
      steps_reg <= steps_next;
      done_reg  <= done_next;
    end
  end

  assign busy  = (state_reg == SCAN);
  assign done  = done_reg;
  assign lout  = lout_reg;
  assign gout  = gout_reg;
  assign eout  = eout_reg;
  assign steps = steps_reg;

endmodule
